// File: rtl/multitap_echo.sv
// Multi-tap echo: per-channel delay line in a shared RAM with feedback and dry/wet mixing.
// Latency 4*CHANNELS+2 bclk from frame strobe to outputs; frames arriving while busy are dropped and flag overrun.
module multitap_echo #(
  parameter int BITSIZE  = 16,
  parameter int ADDRLEN  = 14,
  parameter int CHANNELS = 2
) (
  input  logic                      bclk,
  input  logic                      reset,
  input  logic                      lrclk,
  input  logic                      enable,
  input  logic [1:0]                mode,
  input  logic [2:0]                fb_shift,
  input  logic [ADDRLEN-1:0]        delay,
  input  logic signed [BITSIZE-1:0] in_l,
  input  logic signed [BITSIZE-1:0] in_r,
  output logic signed [BITSIZE-1:0] out_l,
  output logic signed [BITSIZE-1:0] out_r,
  output logic                      clearing,
  output logic                      overrun
);

  localparam int AW    = ADDRLEN + CHANNELS - 1;
  localparam int DEPTH = CHANNELS << ADDRLEN;

  typedef logic signed [BITSIZE-1:0] smp_t;
  typedef logic signed [BITSIZE:0]   wide_t;
  typedef enum logic [2:0] {CLEAR, IDLE, RD, CAP, WR, NEXT, OUT} state_t;

  state_t             state, state_nxt;
  logic               lrclk_q;
  logic               frame;
  logic               ch;
  logic               last_ch;
  logic [ADDRLEN-1:0] wr_ptr;
  logic [ADDRLEN-1:0] rd_ptr;
  logic [AW-1:0]      clr_addr;
  logic [AW-1:0]      rd_addr;
  logic [AW-1:0]      wr_addr;
  logic               mem_we;
  smp_t               mem_wdat;
  smp_t               rd_dat;
  smp_t               in_lat [2];
  smp_t               wet    [2];
  smp_t               cur_in;
  smp_t               wet_sh;
  smp_t               fb_val;
  smp_t               mix_l;
  smp_t               mix_r;
  smp_t               mem    [DEPTH];

  function automatic wide_t wide_sum(input smp_t a, input smp_t b);
    return {a[BITSIZE-1], a} + {b[BITSIZE-1], b};
  endfunction

  // Overflow of a two-operand sum shows as disagreement of the top two bits.
  function automatic smp_t sat(input wide_t v);
    if (v[BITSIZE] != v[BITSIZE-1])
      return v[BITSIZE] ? {1'b1, {(BITSIZE-1){1'b0}}} : {1'b0, {(BITSIZE-1){1'b1}}};
    return v[BITSIZE-1:0];
  endfunction

  function automatic smp_t mix(input logic en, input logic [1:0] md, input smp_t din, input smp_t dwet);
    smp_t half_in;
    smp_t half_wet;
    half_in  = din >>> 1;
    half_wet = dwet >>> 1;
    if (!en)
      return din;
    case (md)
      2'd0:    return dwet;
      2'd1:    return half_in + half_wet;
      default: return sat(wide_sum(din, dwet));
    endcase
  endfunction

  function automatic logic [AW-1:0] addr_of(input logic c, input logic [ADDRLEN-1:0] p);
    return AW'({c, p});
  endfunction

  assign frame    = !lrclk_q && lrclk;
  assign clearing = (state == CLEAR);
  assign last_ch  = (ch == 1'(CHANNELS - 1));
  assign rd_ptr   = wr_ptr - delay;
  assign rd_addr  = addr_of(ch, rd_ptr);
  assign wr_addr  = clearing ? clr_addr : addr_of(ch, wr_ptr);
  assign mem_we   = clearing || (state == WR);
  assign mem_wdat = clearing ? '0 : fb_val;

  always_comb begin
    cur_in = in_lat[ch];
    wet_sh = wet[ch] >>> fb_shift;
    fb_val = cur_in;
    if (fb_shift != 3'd0)
      fb_val = sat(wide_sum(cur_in, wet_sh));
    mix_l = mix(enable, mode, in_lat[0], wet[0]);
    mix_r = mix_l;
    if (CHANNELS > 1)
      mix_r = mix(enable, mode, in_lat[1], wet[1]);
  end

  // RAM: read happens in RD, before the WR of the same frame, so delay=0 sees the oldest sample.
  always_ff @(posedge bclk) begin
    if (mem_we)
      mem[wr_addr] <= mem_wdat;
    if (state == RD)
      rd_dat <= mem[rd_addr];
  end

  always_ff @(posedge bclk or posedge reset) begin
    if (reset)
      state <= CLEAR;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (clr_addr == AW'(DEPTH - 1)) state_nxt = IDLE;
      IDLE:    if (frame) state_nxt = RD;
      RD:      state_nxt = CAP;
      CAP:     state_nxt = WR;
      WR:      state_nxt = NEXT;
      NEXT:    state_nxt = last_ch ? OUT : RD;
      OUT:     state_nxt = IDLE;
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge bclk or posedge reset) begin
    if (reset) begin
      lrclk_q   <= 1'b1;
      ch        <= 1'b0;
      wr_ptr    <= '0;
      clr_addr  <= '0;
      out_l     <= '0;
      out_r     <= '0;
      overrun   <= 1'b0;
      in_lat[0] <= '0;
      in_lat[1] <= '0;
      wet[0]    <= '0;
      wet[1]    <= '0;
    end else begin
      lrclk_q <= lrclk;
      if (frame && state != IDLE && state != CLEAR)
        overrun <= 1'b1;
      case (state)
        CLEAR: clr_addr <= clr_addr + 1'b1;
        IDLE: begin
          if (frame) begin
            in_lat[0] <= in_l;
            in_lat[1] <= in_r;
            ch        <= 1'b0;
          end
        end
        CAP:  wet[ch] <= rd_dat;
        NEXT: if (!last_ch) ch <= ch + 1'b1;
        OUT: begin
          out_l  <= mix_l;
          out_r  <= mix_r;
          wr_ptr <= wr_ptr + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multitap_echo.sv
// Directed bench for multitap_echo: vector table of frames with hand-computed outputs,
// plus sequences for clear sweep, overrun and reset during processing.
module tb_multitap_echo;

  localparam int BITSIZE  = 16;
  localparam int ADDRLEN  = 4;
  localparam int CHANNELS = 2;
  localparam int DEPTH    = CHANNELS << ADDRLEN;

  logic                      bclk = 1'b0;
  logic                      reset = 1'b1;
  logic                      lrclk = 1'b0;
  logic                      enable = 1'b1;
  logic [1:0]                mode = 2'd0;
  logic [2:0]                fb_shift = 3'd0;
  logic [ADDRLEN-1:0]        delay = 4'd3;
  logic signed [BITSIZE-1:0] in_l = '0;
  logic signed [BITSIZE-1:0] in_r = '0;
  logic signed [BITSIZE-1:0] out_l;
  logic signed [BITSIZE-1:0] out_r;
  logic                      clearing;
  logic                      overrun;

  int total = 0;
  int bad   = 0;

  multitap_echo #(.BITSIZE(BITSIZE), .ADDRLEN(ADDRLEN), .CHANNELS(CHANNELS)) dut (
    .bclk(bclk), .reset(reset), .lrclk(lrclk), .enable(enable), .mode(mode),
    .fb_shift(fb_shift), .delay(delay), .in_l(in_l), .in_r(in_r),
    .out_l(out_l), .out_r(out_r), .clearing(clearing), .overrun(overrun)
  );

  always #5 bclk = ~bclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    bit                 rst;
    bit                 en;
    logic [1:0]         md;
    logic [2:0]         fb;
    logic [3:0]         dly;
    logic signed [15:0] il;
    logic signed [15:0] ir;
    logic signed [15:0] el;
    logic signed [15:0] er;
  } vec_t;

  vec_t vq[$];

  task automatic add(input bit rst, input bit en, input int md, input int fb, input int dly,
                     input int il, input int ir, input int el, input int er);
    vq.push_back('{rst, en, 2'(md), 3'(fb), 4'(dly), 16'(il), 16'(ir), 16'(el), 16'(er)});
  endtask

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Counts bclk edges until clearing drops; optionally pulses lrclk during the sweep.
  task automatic wait_clear(input bit pulse, output int n);
    n = 0;
    do begin
      @(posedge bclk);
      #1;
      n++;
      if (pulse)
        lrclk = (n % 4 == 1);
    end while (clearing && n < 200);
    lrclk = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    int n;
    @(negedge bclk);
    reset = 1'b1;
    lrclk = 1'b0;
    #1;
    chk({tag, "_rst_out_l"}, out_l, 0);
    chk({tag, "_rst_clearing"}, 32'(clearing), 1);
    repeat (2) @(negedge bclk);
    reset = 1'b0;
    wait_clear(1'b0, n);
    chk({tag, "_clear_cycles"}, n, DEPTH);
  endtask

  task automatic frame(input logic signed [15:0] l, input logic signed [15:0] r);
    @(negedge bclk);
    in_l  = l;
    in_r  = r;
    lrclk = 1'b1;
    @(negedge bclk);
    lrclk = 1'b0;
    repeat (12) @(negedge bclk);
  endtask

  initial begin
    int n;

    // rst en md fb dly   il      ir      el      er
    add(1, 1, 0, 0, 3,  1000,      0,      0,      0);
    add(0, 1, 0, 0, 3,     0,      7,      0,      0);
    add(0, 1, 0, 0, 3,     0,      0,      0,      0);
    add(0, 1, 0, 0, 3,     0,      0,   1000,      0);
    add(0, 1, 0, 0, 3,     0,      0,      0,      7);
    add(0, 1, 0, 0, 3,     0,      0,      0,      0);
    add(0, 1, 0, 0, 3,     0,      0,      0,      0);
    add(1, 1, 0, 1, 3,  1000,  -2000,      0,      0);
    add(0, 1, 0, 1, 3,     0,      0,      0,      0);
    add(0, 1, 0, 1, 3,     0,      0,      0,      0);
    add(0, 1, 0, 1, 3,     0,      0,   1000,  -2000);
    add(0, 1, 0, 1, 3,     0,      0,      0,      0);
    add(0, 1, 0, 1, 3,     0,      0,      0,      0);
    add(0, 1, 0, 1, 3,     0,      0,    500,  -1000);
    add(0, 1, 0, 1, 3,     0,      0,      0,      0);
    add(0, 1, 0, 1, 3,     0,      0,      0,      0);
    add(0, 1, 0, 1, 3,     0,      0,    250,   -500);
    add(0, 1, 0, 1, 3,     0,      0,      0,      0);
    add(0, 1, 0, 1, 3,     0,      0,      0,      0);
    add(0, 1, 0, 1, 3,     0,      0,    125,   -250);
    add(1, 1, 2, 0, 1, 30000, -30000,  30000, -30000);
    add(0, 1, 2, 0, 1, 30000, -30000,  32767, -32768);
    add(0, 1, 1, 0, 1,  1001,  -1001,  15500, -15501);
    add(0, 0, 0, 0, 1,     6,     -6,      6,     -6);
    add(0, 1, 3, 0, 1,   100,    100,    106,     94);
    add(0, 1, 0, 0, 0,    77,     88,      0,      0);
    for (int k = 6; k < 16; k++)
      add(0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0,     0,      0,  30000, -30000);
    add(0, 1, 0, 0, 0,     0,      0,  30000, -30000);
    add(0, 1, 0, 0, 0,     0,      0,   1001,  -1001);
    add(0, 1, 0, 0, 0,     0,      0,      6,     -6);
    add(0, 1, 0, 0, 0,     0,      0,    100,    100);
    add(0, 1, 0, 0, 0,     0,      0,     77,     88);

    // Power-on reset and clear sweep with frame strobes that must be ignored.
    #1;
    chk("por_out_l", out_l, 0);
    chk("por_out_r", out_r, 0);
    chk("por_overrun", 32'(overrun), 0);
    chk("por_clearing", 32'(clearing), 1);
    repeat (2) @(negedge bclk);
    reset = 1'b0;
    wait_clear(1'b1, n);
    chk("por_clear_cycles", n, DEPTH);
    chk("por_clear_overrun", 32'(overrun), 0);
    repeat (12) @(negedge bclk);
    chk("por_idle_out_l", out_l, 0);
    chk("por_idle_out_r", out_r, 0);

    foreach (vq[i]) begin
      if (vq[i].rst)
        do_reset($sformatf("v%0d", i));
      enable   = vq[i].en;
      mode     = vq[i].md;
      fb_shift = vq[i].fb;
      delay    = vq[i].dly;
      frame(vq[i].il, vq[i].ir);
      chk($sformatf("v%0d_l", i), out_l, vq[i].el);
      chk($sformatf("v%0d_r", i), out_r, vq[i].er);
    end

    // Second strobe three cycles into a frame: dropped, overrun sticks.
    do_reset("ovr");
    enable = 1'b0;
    @(negedge bclk);
    in_l = 111; in_r = -111; lrclk = 1'b1;
    @(negedge bclk);
    lrclk = 1'b0; in_l = 222; in_r = -222;
    @(negedge bclk);
    @(negedge bclk);
    lrclk = 1'b1;
    @(negedge bclk);
    lrclk = 1'b0;
    chk("ovr_set", 32'(overrun), 1);
    repeat (12) @(negedge bclk);
    chk("ovr_pending_l", out_l, 111);
    chk("ovr_pending_r", out_r, -111);
    frame(333, -333);
    chk("ovr_next_l", out_l, 333);
    chk("ovr_sticky", 32'(overrun), 1);

    // Reset while in WR: outputs drop at once, sweep reruns, old echoes are gone.
    do_reset("rwr");
    enable = 1'b1; mode = 2'd0; fb_shift = 3'd0; delay = 4'd3;
    frame(1000, 900);
    frame(0, 0);
    enable = 1'b0;
    frame(555, 444);
    chk("rwr_pre_l", out_l, 555);
    enable = 1'b1;
    @(negedge bclk);
    in_l = 0; in_r = 0; lrclk = 1'b1;
    @(negedge bclk);
    lrclk = 1'b0;
    @(negedge bclk);
    @(negedge bclk);
    reset = 1'b1;
    #1;
    chk("rwr_out_l", out_l, 0);
    chk("rwr_out_r", out_r, 0);
    chk("rwr_clearing", 32'(clearing), 1);
    repeat (2) @(negedge bclk);
    reset = 1'b0;
    wait_clear(1'b0, n);
    chk("rwr_clear_cycles", n, DEPTH);
    for (int k = 0; k < 6; k++) begin
      frame(0, 0);
      chk($sformatf("rwr_stale%0d_l", k), out_l, 0);
      chk($sformatf("rwr_stale%0d_r", k), out_r, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multitap_echo.md
MULTITAP_ECHO -- requirements
Module: multitap_echo

Interface
REQ-001 SHALL have parameter BITSIZE, default 16, sample width; legal values 16 and 24.
REQ-002 SHALL have parameter ADDRLEN, default 14, log2 of per-channel delay depth in frames.
REQ-003 SHALL have parameter CHANNELS, default 2, channel count; legal values 1 and 2.
REQ-004 SHALL have port bclk, input, 1, sole clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-006 SHALL have port lrclk, input, 1, frame strobe sampled as data on bclk.
REQ-007 SHALL have port enable, input, 1; 0 selects bypass.
REQ-008 SHALL have port mode, input, 2; 0 wet only, 1 dry/wet half-sum, 2 and 3 dry plus wet saturated.
REQ-009 SHALL have port fb_shift, input, 3; feedback attenuation 2^-fb_shift; 0 disables feedback.
REQ-010 SHALL have port delay, input, ADDRLEN, echo length in frames, shared by all channels.
REQ-011 SHALL have ports in_l and in_r, input, BITSIZE signed each; in_r is ignored when CHANNELS=1.
REQ-012 SHALL have ports out_l and out_r, output, BITSIZE signed each; out_r mirrors out_l when CHANNELS=1.
REQ-013 SHALL have port clearing, output, 1, high during the post-reset RAM sweep.
REQ-014 SHALL have port overrun, output, 1, sticky; set by a frame lost while busy.

Function
REQ-015 SHALL hold CHANNELS x 2^ADDRLEN words of BITSIZE bits in an internal RAM with synchronous read (1 cycle), addressed {channel, pointer}.
REQ-016 SHALL detect a frame on the bclk cycle where the registered lrclk is 0 and the current lrclk is 1.
REQ-017 SHALL run the FSM states CLEAR, IDLE, RD, CAP, WR, NEXT, OUT.
REQ-018 SHALL, in CLEAR, write 0 to one RAM word per cycle across all words, then enter IDLE; clearing=1 throughout, and frames are neither processed nor counted as overrun.
REQ-019 SHALL, from IDLE on a frame, latch in_l/in_r, set ch=0 and enter RD.
REQ-020 SHALL, in RD, read address {ch, wr_ptr - delay}, with the subtraction modulo 2^ADDRLEN.
REQ-021 SHALL, in CAP, capture the RAM output as wet[ch].
REQ-022 SHALL, in WR, write sat(in[ch] + (wet[ch] >>> fb_shift)) at {ch, wr_ptr}, or in[ch] when fb_shift=0.
REQ-023 SHALL, in NEXT, go to RD with ch+1 if channels remain, otherwise go to OUT.
REQ-024 SHALL, in OUT, update all outputs, increment wr_ptr modulo 2^ADDRLEN, and return to IDLE; frame-to-output latency is 4*CHANNELS+2 bclk cycles.
REQ-025 SHALL, when delay=0, read before write at the same address, yielding the sample from 2^ADDRLEN frames earlier.
REQ-026 SHALL, with enable=0, set out = latched in; with enable=1, out = wet (mode 0), (in>>>1)+(wet>>>1) (mode 1), or sat(in+wet) (modes 2/3).
REQ-027 SHALL saturate to [-2^(BITSIZE-1), 2^(BITSIZE-1)-1] using a BITSIZE+1 intermediate, never wrapping.
REQ-028 SHALL, on a frame in any state other than IDLE or CLEAR, ignore that frame and set overrun.
REQ-029 SHALL take delay, fb_shift, mode and enable from their values at the RD/WR/OUT cycle in which they are used, with no latching.

Reset
REQ-030 SHALL, on reset assertion, immediately set out_l=out_r=0, overrun=0, wr_ptr=0, ch=0, clearing=1 and state CLEAR, including mid-frame.
REQ-031 SHALL restart the CLEAR sweep from address 0 after reset release.

Verification
REQ-032 Reset, then hold lrclk low -> clearing drops after exactly CHANNELS*2^ADDRLEN cycles; all words read 0; outputs stay 0.
REQ-033 ADDRLEN=4, delay=3, fb_shift=0, mode=0, enable=1, in_l impulse 1000 at frame 0 -> out_l=1000 at frame 3 only, 0 elsewhere.
REQ-034 Same setup with fb_shift=1 -> out_l = 1000, 500, 250 at frames 3, 6, 9.
REQ-035 BITSIZE=16, mode=2, in=30000, wet=30000 -> out=32767; in=-30000, wet=-30000 -> out=-32768.
REQ-036 Second lrclk rising edge 3 cycles after a frame -> overrun=1 and remains set; the pending frame completes normally.
REQ-037 Reset asserted during WR -> outputs 0 in the same cycle; the CLEAR sweep reruns; stale echoes never reappear.
